grf_wb_buffer: RTL
==================

# grf_wb_buffer

Write-back buffer sitting in front of the GRF's single write port in the MIPS pipeline. It accepts register write requests (rd, value, PC) through a valid/ready handshake, holds them in a small in-order FIFO, and drains one entry per cycle into the GRF write port (WE/A3/WD/PC). It also gives the decode stage two bypass lookups, so a pending write can be forwarded before it reaches the register array.

## Interface
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- req_valid  in  1  write request present.
- req_ready  out  1  buffer can accept a request this cycle.
- req_addr  in  5  destination register number.
- req_data  in  32  value to write.
- req_pc  in  32  PC of the producing instruction, carried for the GRF write log.
- wb_stall  in  1  when high, the head entry is held and not drained this cycle.
- WE  out  1  GRF write enable.
- A3  out  5  GRF write address.
- WD  out  32  GRF write data.
- PC  out  32  PC forwarded to the GRF for logging.
- q1_addr, q2_addr  in  5 each  bypass lookup addresses.
- q1_hit, q2_hit  out  1 each  a pending entry targets qN_addr.
- q1_data, q2_data  out  32 each  value of the youngest matching pending entry.

## Operation
- Enqueue occurs when req_valid && req_ready at a rising edge. A request with req_addr == 0 completes the handshake but is discarded and never occupies an entry.
- req_ready = (count != DEPTH). It depends only on registered count. A drain in the same cycle does not open a slot while the buffer is full.
- Head presentation: WE = (count != 0) && !wb_stall. A3/WD/PC equal the head entry while count != 0 and are 0 when empty.
- Drain: when WE is 1 at a rising edge, the head is retired and the read pointer advances. The GRF samples the same edge.
- Simultaneous enqueue and drain leaves count unchanged and moves both pointers.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- Bypass: qN_hit = 1 iff some valid entry has addr == qN_addr and qN_addr != 0. qN_data is taken from the youngest such entry (closest to the write pointer). On a miss qN_data = 0. The lookup is purely combinational over the registered entries and does not consider the request being enqueued in the same cycle.
- Ordering: entries retire strictly in arrival order. Two pending writes to the same register both reach the GRF, oldest first.

## Timing
- Reset values: count=0, pointers=0, all entries invalid, req_ready=1, WE=0, A3=0, WD=0, PC=0, q1_hit/q2_hit=0, q1_data/q2_data=0.
- Latency: a request accepted at edge N drives WE=1 during cycle N+1 (if not stalled) and is written at edge N+1.
- Throughput: one enqueue and one drain per cycle.
- wb_stall=1 holds the head stable for any number of cycles. Enqueues continue until full.
- reset asserted mid-operation discards all pending entries at that edge, with no GRF write in that cycle.

## Configuration
- GRF_WB_BYPASS_EN defined: the qN lookup logic is built as described above.
- GRF_WB_BYPASS_EN undefined: the lookup logic is omitted and qN_hit/qN_data are tied to 0. The qN_addr ports remain for interface stability. Write ordering and the handshake are unchanged.

## Structure
- Shared package mips_pkg holds:
  - the WB_DEPTH default constant;
  - the wb_entry_t typedef {addr[4:0], data[31:0], pc[31:0]}.
- One sub-module, grf_wb_match: a priority search of entries from youngest to oldest for one query address. It is instantiated twice, for q1 and q2.

## Test plan
- Reset then idle: WE=0, A3/WD/PC=0, req_ready=1, q1_hit=0 for 3 cycles.
- Enqueue ($5, 0x1234, pc 0x3000) at edge N, wb_stall=0: cycle N+1 shows WE=1, A3=5, WD=0x1234, PC=0x3000. Cycle N+2 shows WE=0.
- Write-back ordering and bypass: hold wb_stall=1 and enqueue $8=0xAAAA then $8=0xBBBB. Set q1_addr=8: q1_hit=1, q1_data=0xBBBB. Release the stall: the GRF sees 0xAAAA, then 0xBBBB, on consecutive cycles.
- Fill and ready: with wb_stall=1, enqueue DEPTH writes. req_ready drops to 0, and a further request is not accepted. One cycle after the stall is released, req_ready=1.
- Writes to register 0: enqueue ($0, 0xFFFF). Required: the request is accepted, count stays 0, WE stays 0, and q2_addr=0 gives q2_hit=0.
- Reset mid-operation: with 3 entries pending and wb_stall=1, assert reset for 1 cycle. Afterwards WE=0, req_ready=1, and all bypass lookups miss.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: write-back entry layout and buffer depth.
// Pulled into the write-back buffer files with import mips_pkg::*.
package mips_pkg;

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_buffer_if.sv
// Request handshake into the GRF write-back buffer.
// master = producing pipeline stage, slave = buffer.
interface grf_wb_buffer_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic [31:0] req_pc;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output req_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  req_pc,
    output req_ready
  );

endinterface

// File: rtl/grf_wb_match.sv
// Youngest-first search of pending write-back entries
// for one bypass query address.
module grf_wb_match
  import mips_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ent_i,
  input  logic [DEPTH-1:0]      vld_i,
  input  logic [PW-1:0]         wr_ptr_i,
  input  logic [4:0]            addr_i,
  output logic                  hit_o,
  output logic [31:0]           data_o
);

  logic [PW-1:0] idx;

  // Walk oldest slot to youngest; later matches override.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_i - PW'(k);
      if (vld_i[idx] && addr_i != 5'd0 &&
          ent_i[idx].addr == addr_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/grf_wb_buffer.sv
// In-order write-back FIFO in front of the GRF write port.
// Define GRF_WB_BYPASS_EN to build the q1/q2 bypass lookups.
module grf_wb_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  grf_wb_buffer_if.slave    req,
  input  logic              wb_stall,
  output logic              WE,
  output logic [4:0]        A3,
  output logic [31:0]       WD,
  output logic [31:0]       PC,
  input  logic [4:0]        q1_addr,
  input  logic [4:0]        q2_addr,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [31:0]       q1_data,
  output logic [31:0]       q2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic      enq;
  logic      deq;
  logic      busy;
  wb_entry_t head;

  assign busy          = (count_q != '0);
  assign head          = ent_q[rd_ptr_q];
  assign req.req_ready = (count_q != FULL);

  // No GRF write in a reset cycle; the pending entries are dropped.
  assign deq = busy && !wb_stall && !reset;
  assign enq = req.req_valid && req.req_ready &&
               (req.req_addr != 5'd0);

  assign WE = deq;
  assign A3 = busy ? head.addr : '0;
  assign WD = busy ? head.data : '0;
  assign PC = busy ? head.pc   : '0;

  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (deq) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      ent_d[wr_ptr_q] = '{addr: req.req_addr,
                          data: req.req_data,
                          pc:   req.req_pc};
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef GRF_WB_BYPASS_EN
  grf_wb_match #(.DEPTH(DEPTH)) u_match_q1 (
    .ent_i    (ent_q),
    .vld_i    (vld_q),
    .wr_ptr_i (wr_ptr_q),
    .addr_i   (q1_addr),
    .hit_o    (q1_hit),
    .data_o   (q1_data)
  );

  grf_wb_match #(.DEPTH(DEPTH)) u_match_q2 (
    .ent_i    (ent_q),
    .vld_i    (vld_q),
    .wr_ptr_i (wr_ptr_q),
    .addr_i   (q2_addr),
    .hit_o    (q2_hit),
    .data_o   (q2_data)
  );
`else
  logic unused_qaddr;
  assign unused_qaddr = ^{q1_addr, q2_addr};
  assign q1_hit  = 1'b0;
  assign q2_hit  = 1'b0;
  assign q1_data = '0;
  assign q2_data = '0;
`endif

endmodule
